uart_cmd_assembler: RTL

//  Parametrised UART command-frame assembler: collects N_OPS operands of OP_BYTES bytes each plus one
//  CMD byte from the UART receiver, presents the complete frame to the execution/TX stage with a

---
 rtl/uart_cmd_assembler.sv | 97 +++++++++
 1 files changed

// File: rtl/uart_cmd_assembler.sv
// uart_cmd_assembler: gathers N_OPS operands of OP_BYTES bytes plus a CMD byte from the UART RX
// byte stream and hands the frame over with a valid/ack handshake; stalled frames are dropped by timeout.
module uart_cmd_assembler #(
    parameter int N_OPS       = 2,
    parameter int OP_BYTES    = 2,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    rx_ready,
    input  logic [7:0]                              rx_data,
    output logic [N_OPS*OP_BYTES*8-1:0]             operands,
    output logic [7:0]                              cmd,
    output logic                                    frame_valid,
    input  logic                                    frame_ack,
    output logic                                    busy,
    output logic [$clog2(N_OPS*OP_BYTES+2)-1:0]     byte_cnt,
    output logic                                    timeout_err,
    output logic                                    overrun_err
);
    localparam int NB = N_OPS * OP_BYTES;
    localparam int CW = $clog2(NB + 2);
    localparam int TW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic {COLLECT, ISSUE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [NB*8-1:0] ops_q, ops_d;
    logic [7:0]      cmd_q, cmd_d;
    logic            terr_q, terr_d;
    logic            oerr_q, oerr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            tmo_q   <= '0;
            ops_q   <= '0;
            cmd_q   <= '0;
            terr_q  <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            ops_q   <= ops_d;
            cmd_q   <= cmd_d;
            terr_q  <= terr_d;
            oerr_q  <= oerr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        ops_d   = ops_q;
        cmd_d   = cmd_q;
        terr_d  = 1'b0;
        oerr_d  = 1'b0;
        if (state_q == ISSUE) begin
            // Bytes arriving while a frame is pending are dropped; ack still wins the exit.
            oerr_d = rx_ready;
            state_d = frame_ack ? COLLECT : ISSUE;
        end else if (rx_ready) begin
            tmo_d = '0;
            if (cnt_q == CW'(NB)) begin
                cmd_d   = rx_data;
                cnt_d   = '0;
                state_d = ISSUE;
            end else begin
                for (int i = 0; i < NB; i++)
                    if (cnt_q == CW'(i)) ops_d[i*8 +: 8] = rx_data;
                cnt_d = cnt_q + CW'(1);
            end
        end else if (TIMEOUT_CYC > 0 && cnt_q != '0) begin
            // Stale operand bytes are left in place; only the frame position is abandoned.
            if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                cnt_d  = '0;
                tmo_d  = '0;
                terr_d = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    assign operands    = ops_q;
    assign cmd         = cmd_q;
    assign frame_valid = state_q == ISSUE;
    assign busy        = cnt_q != '0 || state_q == ISSUE;
    assign byte_cnt    = cnt_q;
    assign timeout_err = terr_q;
    assign overrun_err = oerr_q;
endmodule
